human_detect_alarm_ctrl: RTL and testbench

Sequencing controller for the human-detector alarm datapath.
- Arms and disarms the detector, with an exit delay after arming.
- Qualifies the raw detect input: synchronises it, then requires CONFIRM_N consecutive high samples.
- Drives alarm, display_a and display_b with defined hold, retrigger, acknowledge and cooldown timing.
- Keeps a saturating count of alarm events.
- Sits between the sensor front-end and the alarm LED/display drivers.

---
 rtl/human_detect_alarm_ctrl.sv | 161 ++++++++++++++++
 tb/tb_human_detect_alarm_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/human_detect_alarm_ctrl.sv
// Human-detector alarm sequencer: arming delay, detect qualification,
// alarm hold/retrigger/acknowledge, cooldown and a saturating event counter.
module human_detect_alarm_ctrl #(
   parameter int ARM_DLY   = 16,
   parameter int CONFIRM_N = 4,
   parameter int HOLD_CYC  = 32,
   parameter int COOL_CYC  = 8,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             arm,
   input  logic             detect,
   input  logic             ack,
   output logic             alarm,
   output logic             display_a,
   output logic             display_b,
   output logic [CNT_W-1:0] event_cnt,
   output logic [2:0]       state
);

   localparam logic [2:0] S_DISARMED = 3'd0;
   localparam logic [2:0] S_ARMING   = 3'd1;
   localparam logic [2:0] S_ARMED    = 3'd2;
   localparam logic [2:0] S_CONFIRM  = 3'd3;
   localparam logic [2:0] S_ALARM    = 3'd4;
   localparam logic [2:0] S_COOLDOWN = 3'd5;

   localparam int MAX_AH = (ARM_DLY > HOLD_CYC) ? ARM_DLY : HOLD_CYC;
   localparam int MAX_T  = (MAX_AH > COOL_CYC) ? MAX_AH : COOL_CYC;
   localparam int TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;
   localparam int RW     = (CONFIRM_N > 1) ? $clog2(CONFIRM_N) : 1;

   localparam logic [TW-1:0] ARM_LOAD  = TW'(ARM_DLY - 1);
   localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYC - 1);
   localparam logic [TW-1:0] COOL_LOAD = TW'(COOL_CYC - 1);
   localparam logic [RW-1:0] RUN_LAST  = RW'(CONFIRM_N - 1);

   logic [1:0]       sync_q;
   logic             det_s;
   logic [2:0]       state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [RW-1:0]    run_q, run_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             alarm_q, alarm_d;
   logic             disp_a_q, disp_a_d;
   logic             disp_b_q, disp_b_d;

   assign det_s = sync_q[1];

   // State, timers, synchroniser and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= 2'b00;
         state_q  <= S_DISARMED;
         timer_q  <= '0;
         run_q    <= '0;
         cnt_q    <= '0;
         alarm_q  <= 1'b0;
         disp_a_q <= 1'b0;
         disp_b_q <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], detect};
         state_q  <= state_d;
         timer_q  <= timer_d;
         run_q    <= run_d;
         cnt_q    <= cnt_d;
         alarm_q  <= alarm_d;
         disp_a_q <= disp_a_d;
         disp_b_q <= disp_b_d;
      end
   end

   // Next-state, timer and confirmation-run logic
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      run_d   = run_q;
      if (!arm) begin
         state_d = S_DISARMED;
         timer_d = '0;
         run_d   = '0;
      end else begin
         case (state_q)
            S_DISARMED: begin
               state_d = S_ARMING;
               timer_d = ARM_LOAD;
            end
            S_ARMING: begin
               if (timer_q == '0) state_d = S_ARMED;
               else               timer_d = timer_q - TW'(1);
            end
            S_ARMED: begin
               if (det_s && (CONFIRM_N == 1)) begin
                  state_d = S_ALARM;
                  timer_d = HOLD_LOAD;
               end else if (det_s) begin
                  state_d = S_CONFIRM;
                  run_d   = RW'(1);
               end else begin
                  run_d   = '0;
               end
            end
            S_CONFIRM: begin
               if (!det_s) begin
                  state_d = S_ARMED;
                  run_d   = '0;
               end else if (run_q == RUN_LAST) begin
                  state_d = S_ALARM;
                  timer_d = HOLD_LOAD;
                  run_d   = '0;
               end else begin
                  run_d   = run_q + RW'(1);
               end
            end
            S_ALARM: begin
               // Acknowledge beats a simultaneous retrigger
               if (ack) begin
                  state_d = S_COOLDOWN;
                  timer_d = COOL_LOAD;
               end else if (det_s) begin
                  timer_d = HOLD_LOAD;
               end else if (timer_q == '0) begin
                  state_d = S_COOLDOWN;
                  timer_d = COOL_LOAD;
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
            S_COOLDOWN: begin
               if (timer_q == '0) state_d = S_ARMED;
               else               timer_d = timer_q - TW'(1);
            end
            default: begin
               state_d = S_DISARMED;
               timer_d = '0;
               run_d   = '0;
            end
         endcase
      end
   end

   // Outputs derived from the next state so they line up with state_q
   always_comb begin
      alarm_d  = (state_d == S_ALARM);
      disp_a_d = det_s && ((state_d == S_ARMED) || (state_d == S_CONFIRM) ||
                           (state_d == S_ALARM));
      disp_b_d = (state_d == S_ARMING) || (state_d == S_COOLDOWN);
      if ((state_d == S_ALARM) && (state_q != S_ALARM) && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
      else
         cnt_d = cnt_q;
   end

   assign alarm     = alarm_q;
   assign display_a = disp_a_q;
   assign display_b = disp_b_q;
   assign event_cnt = cnt_q;
   assign state     = state_q;

endmodule

// File: tb/tb_human_detect_alarm_ctrl.sv
// Bench for human_detect_alarm_ctrl: directed scenarios plus random traffic,
// every cycle compared against an elapsed-time reference model.
module tb_human_detect_alarm_ctrl;

   localparam int ARM_DLY   = 16;
   localparam int CONFIRM_N = 4;
   localparam int HOLD_CYC  = 32;
   localparam int COOL_CYC  = 8;
   localparam int CNT_W     = 2;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n, arm, detect, ack;
   logic             alarm, display_a, display_b;
   logic [CNT_W-1:0] event_cnt;
   logic [2:0]       state;

   int total = 0;
   int bad   = 0;

   // reference model: phase code plus elapsed-cycle counters
   int m_ph, m_age, m_run, m_quiet, m_cnt;
   bit m_p1, m_p2, m_disp_a;

   human_detect_alarm_ctrl #(
      .ARM_DLY(ARM_DLY), .CONFIRM_N(CONFIRM_N), .HOLD_CYC(HOLD_CYC),
      .COOL_CYC(COOL_CYC), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .detect(detect), .ack(ack),
      .alarm(alarm), .display_a(display_a), .display_b(display_b),
      .event_cnt(event_cnt), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ph = 0; m_age = 0; m_run = 0; m_quiet = 0; m_cnt = 0;
      m_p1 = 1'b0; m_p2 = 1'b0; m_disp_a = 1'b0;
   endtask

   task automatic enter_alarm();
      m_ph = 4;
      m_quiet = 0;
      if (m_cnt < CNT_MAX) m_cnt++;
   endtask

   task automatic model_edge();
      bit ds;
      if (!rst_n) begin
         model_reset();
         return;
      end
      ds = m_p2;
      m_p2 = m_p1;
      m_p1 = detect;
      if (!arm) begin
         m_ph = 0;
      end else begin
         case (m_ph)
            0: begin m_ph = 1; m_age = 0; end
            1: begin m_age++; if (m_age == ARM_DLY) m_ph = 2; end
            2: if (ds) begin
                  m_run = 1;
                  if (m_run == CONFIRM_N) enter_alarm(); else m_ph = 3;
               end
            3: if (!ds) m_ph = 2;
               else begin
                  m_run++;
                  if (m_run == CONFIRM_N) enter_alarm();
               end
            4: if (ack) begin m_ph = 5; m_age = 0; end
               else if (ds) m_quiet = 0;
               else begin
                  m_quiet++;
                  if (m_quiet == HOLD_CYC) begin m_ph = 5; m_age = 0; end
               end
            5: begin m_age++; if (m_age == COOL_CYC) m_ph = 2; end
            default: m_ph = 0;
         endcase
      end
      m_disp_a = ds && (m_ph >= 2) && (m_ph <= 4);
   endtask

   task automatic check_all();
      chk("state",     state,     m_ph);
      chk("alarm",     alarm,     m_ph == 4);
      chk("display_a", display_a, m_disp_a);
      chk("display_b", display_b, (m_ph == 1) || (m_ph == 5));
      chk("event_cnt", event_cnt, m_cnt);
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         #1;
         check_all();
      end
   endtask

   task automatic trigger();
      detect = 1'b1;
      step(CONFIRM_N + 3);
      detect = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; arm = 1'b0; detect = 1'b0; ack = 1'b0;
      model_reset();
      #1;
      check_all();
      step(2);
      @(negedge clk);
      rst_n = 1'b1;
      arm   = 1'b1;

      // arming with detect high early: must not alarm
      detect = 1'b1;
      step(10);
      detect = 1'b0;
      step(10);

      // held detect -> alarm, hold, cooldown, back to armed
      trigger();
      step(HOLD_CYC + COOL_CYC + 5);

      // short pulses never reach confirmation
      for (int p = 0; p < 10; p++) begin
         detect = 1'b1; step(3);
         detect = 1'b0; step(2);
      end

      // retrigger every 20 cycles keeps alarm asserted
      trigger();
      for (int p = 0; p < 5; p++) begin
         step(17);
         detect = 1'b1; step(3); detect = 1'b0;
      end
      step(HOLD_CYC + COOL_CYC + 4);

      // acknowledge mid-alarm, with detect also high
      trigger();
      step(5);
      detect = 1'b1; ack = 1'b1; step(1);
      ack = 1'b0; detect = 1'b0;
      step(COOL_CYC + 4);

      // disarm together with ack mid-alarm
      trigger();
      step(4);
      arm = 1'b0; ack = 1'b1; step(1);
      ack = 1'b0; step(2);
      arm = 1'b1; step(ARM_DLY + 3);
      chk("cnt_sat", event_cnt, CNT_MAX);

      // randomized traffic
      for (int c = 0; c < 2500; c++) begin
         if ($urandom_range(7) == 0) detect = ~detect;
         arm = ($urandom_range(199) != 0);
         ack = ($urandom_range(39) == 0);
         step(1);
      end
      arm = 1'b1; ack = 1'b0; detect = 1'b0;
      step(ARM_DLY + HOLD_CYC + COOL_CYC + 4);

      // asynchronous reset in the middle of an alarm
      trigger();
      step(3);
      chk("pre_rst_alarm", alarm, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_alarm", alarm, 1'b0);
      chk("rst_state", state, 3'd0);
      chk("rst_cnt",   event_cnt, 0);
      chk("rst_dispb", display_b, 1'b0);
      model_reset();
      step(2);
      @(negedge clk);
      rst_n = 1'b1;
      step(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
